// File: rtl/reg_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : reg_scoreboard
// Purpose  : RAW/WAW hazard controller for the integer register file. Tracks
//            in-flight destination writes per register, holds issue until all
//            sources and the destination slot are clear, and flags writebacks
//            that have no matching issued write.
// Options  : REG_SCOREBOARD_STATS_EN - adds a saturating stall-cycle counter;
//            when undefined, stall_cycles is tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
module reg_scoreboard #(
    parameter int NUM_REGS    = 32,
    parameter int REG_IDX_W   = 5,
    parameter int MAX_PENDING = 3
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 issue_valid,
    output logic                 issue_ready,
    input  logic [REG_IDX_W-1:0] issue_rs1,
    input  logic                 issue_rs1_used,
    input  logic [REG_IDX_W-1:0] issue_rs2,
    input  logic                 issue_rs2_used,
    input  logic [REG_IDX_W-1:0] issue_rd,
    input  logic                 issue_rd_write,
    input  logic                 wb_valid,
    input  logic [REG_IDX_W-1:0] wb_rd,
    input  logic                 flush,
    output logic [NUM_REGS-1:0]  busy_mask,
    output logic                 error,
    output logic [31:0]          stall_cycles
);

    localparam int                c_cnt_w   = $clog2(MAX_PENDING + 1);
    localparam logic [c_cnt_w-1:0] c_max_cnt = c_cnt_w'(MAX_PENDING);

    // Flat view of all per-register counts; x0 is permanently zero.
    logic [c_cnt_w-1:0] w_count [NUM_REGS];
    logic               w_rs1_hazard;
    logic               w_rs2_hazard;
    logic               w_rd_full;
    logic               w_fire;
    logic               w_orphan_wb;
    logic               r_error;

    assign w_count[0]   = '0;
    assign busy_mask[0] = 1'b0;

    // Readiness uses registered counts only, so a writeback in the same cycle
    // cannot release a waiting source (the register file would still return
    // the old value).
    assign w_rs1_hazard = issue_rs1_used && (issue_rs1 != '0) && (w_count[issue_rs1] != '0);
    assign w_rs2_hazard = issue_rs2_used && (issue_rs2 != '0) && (w_count[issue_rs2] != '0);
    assign w_rd_full    = issue_rd_write && (issue_rd != '0) && (w_count[issue_rd] == c_max_cnt);
    assign issue_ready  = !(w_rs1_hazard || w_rs2_hazard || w_rd_full || flush);
    assign w_fire       = issue_valid && issue_ready;

    // Writeback to x1..xN that has nothing in flight; x0 is ignored.
    assign w_orphan_wb  = wb_valid && (wb_rd != '0) && (w_count[wb_rd] == '0);

    generate
        for (genvar gi = 1; gi < NUM_REGS; gi++) begin : g_reg
            logic [c_cnt_w-1:0] r_cnt;
            logic               w_inc;
            logic               w_dec;

            assign w_inc = w_fire && issue_rd_write && (issue_rd == REG_IDX_W'(gi));
            assign w_dec = wb_valid && (wb_rd == REG_IDX_W'(gi)) && (r_cnt != '0);

            // Pending-write counter: flush wins, simultaneous issue+wb cancel.
            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    r_cnt <= '0;
                end else if (flush) begin
                    r_cnt <= '0;
                end else if (w_inc && !w_dec) begin
                    r_cnt <= r_cnt + 1'b1;
                end else if (w_dec && !w_inc) begin
                    r_cnt <= r_cnt - 1'b1;
                end
            end

            assign w_count[gi]   = r_cnt;
            assign busy_mask[gi] = (r_cnt != '0);
        end
    endgenerate

    // Sticky error on an unmatched writeback; a flush cycle ignores writeback.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_error <= 1'b0;
        end else if (!flush && w_orphan_wb) begin
            r_error <= 1'b1;
        end
    end

    assign error = r_error;

`ifdef REG_SCOREBOARD_STATS_EN
    logic [31:0] r_stall_cycles;

    // Count cycles where decode is blocked by a hazard (not by a flush).
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_stall_cycles <= '0;
        end else if (issue_valid && !issue_ready && !flush && (r_stall_cycles != 32'hFFFF_FFFF)) begin
            r_stall_cycles <= r_stall_cycles + 32'd1;
        end
    end

    assign stall_cycles = r_stall_cycles;
`else
    assign stall_cycles = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_reg_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_scoreboard
// Purpose  : Self-checking bench for reg_scoreboard. A vector table drives
//            issue/writeback/flush traffic; issue_ready is compared in-cycle
//            and the expected post-edge busy_mask/error are queued and popped
//            after the clock edge. Hand sequences cover async reset and stats.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reg_scoreboard;

    logic        clock;
    logic        reset_n;
    logic        issue_valid;
    logic        issue_ready;
    logic [4:0]  issue_rs1;
    logic        issue_rs1_used;
    logic [4:0]  issue_rs2;
    logic        issue_rs2_used;
    logic [4:0]  issue_rd;
    logic        issue_rd_write;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic        flush;
    logic [31:0] busy_mask;
    logic        error;
    logic [31:0] stall_cycles;

    int checks = 0;
    int errors = 0;

    reg_scoreboard #(
        .NUM_REGS    (32),
        .REG_IDX_W   (5),
        .MAX_PENDING (3)
    ) u_dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .issue_valid    (issue_valid),
        .issue_ready    (issue_ready),
        .issue_rs1      (issue_rs1),
        .issue_rs1_used (issue_rs1_used),
        .issue_rs2      (issue_rs2),
        .issue_rs2_used (issue_rs2_used),
        .issue_rd       (issue_rd),
        .issue_rd_write (issue_rd_write),
        .wb_valid       (wb_valid),
        .wb_rd          (wb_rd),
        .flush          (flush),
        .busy_mask      (busy_mask),
        .error          (error),
        .stall_cycles   (stall_cycles)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        iv;
        logic [4:0]  rs1;
        logic        u1;
        logic [4:0]  rs2;
        logic        u2;
        logic [4:0]  rd;
        logic        rw;
        logic        wv;
        logic [4:0]  wrd;
        logic        fl;
        logic        ready;  // expected issue_ready this cycle
        logic [31:0] busy;   // expected busy_mask after the edge
        logic        err;    // expected error after the edge
    } vec_t;

    typedef struct {
        int          idx;
        logic [31:0] busy;
        logic        err;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    function automatic logic [31:0] b(input int n);
        logic [31:0] m;
        m = 32'd1 << n;
        return m;
    endfunction

    task automatic add(input logic iv, input int rs1, input logic u1, input int rs2, input logic u2,
                       input int rd, input logic rw, input logic wv, input int wrd, input logic fl,
                       input logic ready, input logic [31:0] busy, input logic err);
        vec_t v;
        v.iv = iv; v.rs1 = 5'(rs1); v.u1 = u1; v.rs2 = 5'(rs2); v.u2 = u2;
        v.rd = 5'(rd); v.rw = rw; v.wv = wv; v.wrd = 5'(wrd); v.fl = fl;
        v.ready = ready; v.busy = busy; v.err = err;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        issue_valid = 0; issue_rs1 = 0; issue_rs1_used = 0; issue_rs2 = 0; issue_rs2_used = 0;
        issue_rd = 0; issue_rd_write = 0; wb_valid = 0; wb_rd = 0; flush = 0;
    endtask

    initial begin
        int   exp_stall;
        exp_t e;

        // iv rs1 u1 rs2 u2 rd rw wv wrd fl | ready busy err
        add(0, 0,0, 0,0, 0,0, 0,0, 0, 1, 32'h0, 0);                 // idle
        add(1, 0,0, 0,0, 5,1, 0,0, 0, 1, b(5), 0);                  // issue rd=5
        add(1, 5,1, 0,0, 0,0, 0,0, 0, 0, b(5), 0);                  // RAW on x5
        add(1, 5,1, 0,0, 0,0, 1,5, 0, 0, 32'h0, 0);                 // wb x5, no same-cycle release
        add(1, 5,1, 0,0, 0,0, 0,0, 0, 1, 32'h0, 0);                 // released next cycle
        add(1, 0,0, 0,0, 7,1, 0,0, 0, 1, b(7), 0);                  // x7 -> 1
        add(1, 0,0, 0,0, 7,1, 0,0, 0, 1, b(7), 0);                  // x7 -> 2
        add(1, 0,0, 0,0, 7,1, 0,0, 0, 1, b(7), 0);                  // x7 -> 3
        add(1, 0,0, 0,0, 7,1, 0,0, 0, 0, b(7), 0);                  // full: blocked
        add(1, 0,0, 0,0, 7,1, 1,7, 0, 0, b(7), 0);                  // full + wb: blocked, 3 -> 2
        add(1, 0,0, 0,0, 7,1, 1,7, 0, 1, b(7), 0);                  // issue + wb: stays 2
        add(1, 0,0, 0,0, 7,1, 0,0, 0, 1, b(7), 0);                  // 2 -> 3
        add(1, 0,0, 0,0, 7,1, 0,0, 0, 0, b(7), 0);                  // full again
        add(0, 0,0, 0,0, 0,0, 1,7, 0, 1, b(7), 0);                  // 3 -> 2
        add(0, 0,0, 0,0, 0,0, 1,7, 0, 1, b(7), 0);                  // 2 -> 1
        add(0, 0,0, 0,0, 0,0, 1,7, 0, 1, 32'h0, 0);                 // 1 -> 0
        add(0, 0,0, 0,0, 0,0, 1,0, 0, 1, 32'h0, 0);                 // wb x0: no error
        add(0, 0,0, 0,0, 0,0, 1,9, 0, 1, 32'h0, 1);                 // orphan wb x9
        add(0, 0,0, 0,0, 0,0, 0,0, 0, 1, 32'h0, 1);                 // error sticky
        add(1, 0,0, 0,0, 3,1, 0,0, 0, 1, b(3), 1);
        add(1, 0,0, 0,0, 4,1, 0,0, 0, 1, b(3)|b(4), 1);
        add(1, 0,0, 0,0,10,1, 0,0, 0, 1, b(3)|b(4)|b(10), 1);
        add(1, 0,0, 0,0,11,1, 1,3, 1, 0, 32'h0, 1);                 // flush beats issue + wb
        add(1,11,1, 3,1, 0,0, 0,0, 0, 1, 32'h0, 1);                 // x11 never tracked
        add(1, 0,0, 0,0,12,1, 0,0, 0, 1, b(12), 1);
        add(1,12,0,12,1, 0,0, 0,0, 0, 0, b(12), 1);                 // RAW via rs2 only
        add(1, 0,1, 0,0, 0,1, 0,0, 0, 1, b(12), 1);                 // x0 source/dest ignored
        add(1,12,0, 0,0, 0,0, 0,0, 0, 1, b(12), 1);                 // unused rs1 ignored

        idle_inputs();
        reset_n = 1'b0;
        #2;
        chk("reset_busy",  busy_mask,    32'h0);
        chk("reset_error", {31'b0, error}, 32'h0);
        chk("reset_stall", stall_cycles, 32'h0);
        chk("reset_ready", {31'b0, issue_ready}, 32'h1);
        @(negedge clock);
        reset_n = 1'b1;

        exp_stall = 0;
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clock);
            issue_valid = vecs[i].iv; issue_rs1 = vecs[i].rs1; issue_rs1_used = vecs[i].u1;
            issue_rs2 = vecs[i].rs2; issue_rs2_used = vecs[i].u2; issue_rd = vecs[i].rd;
            issue_rd_write = vecs[i].rw; wb_valid = vecs[i].wv; wb_rd = vecs[i].wrd; flush = vecs[i].fl;
            #1;
            chk($sformatf("v%0d_ready", i), {31'b0, issue_ready}, {31'b0, vecs[i].ready});
            if (vecs[i].iv && !vecs[i].ready && !vecs[i].fl) exp_stall++;
            e.idx = i; e.busy = vecs[i].busy; e.err = vecs[i].err;
            sb.push_back(e);
            @(posedge clock);
            #1;
            e = sb.pop_front();
            chk($sformatf("v%0d_busy", e.idx), busy_mask, e.busy);
            chk($sformatf("v%0d_error", e.idx), {31'b0, error}, {31'b0, e.err});
        end

`ifdef REG_SCOREBOARD_STATS_EN
        chk("table_stall", stall_cycles, 32'(exp_stall));
`else
        chk("table_stall", stall_cycles, 32'h0);
`endif

        // Async reset mid-cycle with x12 busy and error set.
        @(negedge clock);
        idle_inputs();
        #2;
        reset_n = 1'b0;
        #1;
        chk("midreset_busy",  busy_mask, 32'h0);
        chk("midreset_error", {31'b0, error}, 32'h0);
        chk("midreset_stall", stall_cycles, 32'h0);
        @(negedge clock);
        reset_n = 1'b1;

        // Issue rd=12 plus an orphan wb on x20, then stall on x12 for 4 cycles.
        @(negedge clock);
        issue_valid = 1; issue_rd = 12; issue_rd_write = 1; wb_valid = 1; wb_rd = 20;
        @(negedge clock);
        idle_inputs();
        chk("seq_busy12", busy_mask, b(12));
        chk("seq_error",  {31'b0, error}, 32'h1);
        issue_valid = 1; issue_rs1 = 12; issue_rs1_used = 1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk($sformatf("stall%0d_ready", k), {31'b0, issue_ready}, 32'h0);
            @(negedge clock);
        end
`ifdef REG_SCOREBOARD_STATS_EN
        chk("stall_count4", stall_cycles, 32'd4);
`else
        chk("stall_count4", stall_cycles, 32'd0);
`endif
        // Reset while still stalled: everything clears without a clock edge.
        #2;
        reset_n = 1'b0;
        #1;
        chk("stallreset_busy",  busy_mask, 32'h0);
        chk("stallreset_error", {31'b0, error}, 32'h0);
        chk("stallreset_stall", stall_cycles, 32'h0);
        chk("stallreset_ready", {31'b0, issue_ready}, 32'h1);
        @(negedge clock);
        reset_n = 1'b1;
        idle_inputs();
        @(negedge clock);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
